// File: rtl/arq_rx_fsm.sv
// Receive side of a stop-and-wait (alternating-bit) ARQ link: parity/sequence check,
// ack/nack response, duplicate drop, and a small receive FIFO drained by the host.
module arq_rx_fsm #(
    parameter int DW      = 4,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 8,
    parameter int ODD_PAR = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_valid,
    input  logic [DW-1:0]    rx_data,
    input  logic             rx_par,
    input  logic             rx_seq,
    output logic             rx_ready,
    output logic             ack,
    output logic             nack,
    output logic             ack_seq,
    input  logic             rd_en,
    output logic [DW-1:0]    dout,
    output logic             dout_valid,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] nack_cnt,
    output logic [CNT_W-1:0] dup_cnt
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;

    typedef struct packed {
        logic          seq;
        logic          par;
        logic [DW-1:0] data;
    } frame_t;

    state_t        state;
    frame_t        frm;
    logic          exp_seq;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          par_ok, push, pop;

    assign par_ok   = (^{frm.data, frm.par}) == 1'(ODD_PAR);
    assign push     = (state == CHECK) && par_ok && (frm.seq == exp_seq);
    assign pop      = rd_en && !empty;
    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign rx_ready = (state == IDLE) && !full;

    // Frame handshake and response generation; one frame occupies exactly three cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            frm      <= '0;
            exp_seq  <= 1'b0;
            ack      <= 1'b0;
            nack     <= 1'b0;
            ack_seq  <= 1'b0;
            nack_cnt <= '0;
            dup_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_valid && rx_ready) begin
                        frm   <= '{seq: rx_seq, par: rx_par, data: rx_data};
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    ack_seq <= frm.seq;
                    state   <= RESP;
                    if (!par_ok) begin
                        nack <= 1'b1;
                        if (nack_cnt != '1) nack_cnt <= nack_cnt + 1'b1;
                    end else begin
                        // A good frame with a stale seq means our previous ack was lost: re-ack, drop.
                        ack <= 1'b1;
                        if (frm.seq == exp_seq) exp_seq <= ~exp_seq;
                        else if (dup_cnt != '1) dup_cnt <= dup_cnt + 1'b1;
                    end
                end
                RESP: begin
                    ack   <= 1'b0;
                    nack  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= pop;
            if (pop) begin
                dout <= mem[rptr];
                rptr <= rptr + 1'b1;
            end
            if (push) wptr <= wptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage carries no reset; pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= frm.data;
    end
endmodule

// File: tb/tb_arq_rx_fsm.sv
// Bench for arq_rx_fsm: queue-based reference model checked every cycle, directed scenarios, random traffic.
module tb_arq_rx_fsm;
    localparam int DW = 4, DEPTH = 4, CNT_W = 8, ODD_PAR = 0;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic clk = 0, rst = 1, rx_valid = 0, rx_par = 0, rx_seq = 0, rd_en = 0;
    logic [DW-1:0] rx_data = '0;
    logic rx_ready, ack, nack, ack_seq, dout_valid, empty, full;
    logic [DW-1:0] dout;
    logic [CNT_W-1:0] nack_cnt, dup_cnt;

    int checks = 0, failures = 0;

    arq_rx_fsm #(.DW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W), .ODD_PAR(ODD_PAR)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_par(rx_par),
        .rx_seq(rx_seq), .rx_ready(rx_ready), .ack(ack), .nack(nack), .ack_seq(ack_seq),
        .rd_en(rd_en), .dout(dout), .dout_valid(dout_valid), .empty(empty), .full(full),
        .nack_cnt(nack_cnt), .dup_cnt(dup_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Good parity bit for a payload under the configured parity sense.
    function automatic logic gp(input logic [DW-1:0] d);
        return 1'(($countones(d) + ODD_PAR) % 2);
    endfunction

    // Reference model: frame in flight, expected seq, FIFO as a queue, plain counters.
    logic [DW-1:0] mq[$];
    bit            started = 0, m_busy = 0, m_exp = 0;
    bit            m_ack = 0, m_nack = 0, m_aseq = 0, m_dv = 0;
    logic [DW-1:0] m_dout = '0, f_data = '0;
    bit            f_par = 0, f_seq = 0, m_rdy = 0, m_pop = 0;
    int            m_ncnt = 0, m_dcnt = 0, cyc = 0, acc_cyc = 0;

    always @(posedge clk) begin
        cyc++;
        started = 1;
        if (rst) begin
            mq.delete();
            m_busy = 0; m_exp = 0; m_ack = 0; m_nack = 0; m_aseq = 0;
            m_dout = '0; m_dv = 0; m_ncnt = 0; m_dcnt = 0;
        end else begin
            m_rdy = !m_busy && (mq.size() < DEPTH);
            m_pop = rd_en && (mq.size() > 0);
            m_dv  = m_pop;
            if (m_pop) m_dout = mq.pop_front();
            if (m_busy && cyc == acc_cyc + 2) begin
                m_ack = 0; m_nack = 0; m_busy = 0;
            end else if (m_busy && cyc == acc_cyc + 1) begin
                m_aseq = f_seq;
                if (($countones({f_data, f_par}) % 2) != ODD_PAR) begin
                    m_nack = 1;
                    if (m_ncnt < CMAX) m_ncnt++;
                end else begin
                    m_ack = 1;
                    if (f_seq == m_exp) begin
                        mq.push_back(f_data);
                        m_exp = !m_exp;
                    end else if (m_dcnt < CMAX) m_dcnt++;
                end
            end
            if (m_rdy && rx_valid) begin
                m_busy = 1; acc_cyc = cyc;
                f_data = rx_data; f_par = rx_par; f_seq = rx_seq;
            end
        end
    end

    logic [1:0] resp[$];  // {is_ack, seq} per response pulse

    always @(negedge clk) begin
        if (started) begin
            chk("ack", ack, m_ack);
            chk("nack", nack, m_nack);
            if (m_ack || m_nack) chk("ack_seq", ack_seq, m_aseq);
            chk("rx_ready", rx_ready, !m_busy && (mq.size() < DEPTH));
            chk("dout", dout, m_dout);
            chk("dout_valid", dout_valid, m_dv);
            chk("empty", empty, mq.size() == 0);
            chk("full", full, mq.size() == DEPTH);
            chk("nack_cnt", nack_cnt, m_ncnt);
            chk("dup_cnt", dup_cnt, m_dcnt);
            if (ack || nack) resp.push_back({ack, ack_seq});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; rx_valid = 0; rd_en = 0;
        tick(); tick();
        rst = 0;
        resp.delete();
    endtask

    task automatic wait_accept();
        bit ok = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (rx_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL accept_timeout: rx_ready stayed 0, expected 1");
        end
        tick();
        rx_valid = 0;
    endtask

    task automatic send(input logic s, input logic [DW-1:0] d, input logic p);
        rx_seq = s; rx_data = d; rx_par = p; rx_valid = 1;
        wait_accept();
        tick(); tick();
    endtask

    task automatic pop_chk(input logic [DW-1:0] exp);
        rd_en = 1;
        tick();
        rd_en = 0;
        chk("pop_data", dout, exp);
        chk("pop_valid", dout_valid, 1'b1);
    endtask

    initial begin
        logic [DW-1:0] v1 [4];
        v1 = '{4'h0, 4'hA, 4'h3, 4'h2};

        // 1: fill with four good frames, then drain in order
        do_reset();
        chk("reset_empty", empty, 1'b1);
        chk("reset_ready", rx_ready, 1'b1);
        chk("reset_ack_seq", ack_seq, 1'b0);
        for (int i = 0; i < 4; i++) send(1'(i % 2), v1[i], gp(v1[i]));
        chk("t1_resp_count", resp.size(), 4);
        for (int i = 0; i < resp.size(); i++) chk("t1_resp", resp[i], {1'b1, 1'(i % 2)});
        chk("t1_full", full, 1'b1);
        chk("t1_ready", rx_ready, 1'b0);
        for (int i = 0; i < 4; i++) pop_chk(v1[i]);
        chk("t1_empty", empty, 1'b1);

        // 2: parity error then clean resend
        do_reset();
        send(1'b0, 4'h5, 1'b1);
        chk("t2_nack", resp.size() > 0 ? resp[0] : 2'b11, 2'b00);
        chk("t2_nack_cnt", nack_cnt, 1);
        chk("t2_no_push", empty, 1'b1);
        send(1'b0, 4'h5, 1'b0);
        chk("t2_ack", resp.size() > 1 ? resp[1] : 2'b11, 2'b10);
        pop_chk(4'h5);

        // 3: duplicate frame is acked but dropped
        do_reset();
        send(1'b0, 4'h6, 1'b0);
        send(1'b0, 4'h6, 1'b0);
        chk("t3_dup_ack", resp.size() > 1 ? resp[1] : 2'b11, 2'b10);
        chk("t3_dup_cnt", dup_cnt, 1);
        pop_chk(4'h6);
        chk("t3_empty", empty, 1'b1);

        // 4: full FIFO back-pressures a held frame until one pop frees space
        do_reset();
        for (int i = 1; i <= 4; i++) send(1'((i - 1) % 2), 4'(i), gp(4'(i)));
        rx_seq = 0; rx_data = 4'h9; rx_par = gp(4'h9); rx_valid = 1;
        repeat (10) begin
            tick();
            chk("t4_ready_low", rx_ready, 1'b0);
        end
        chk("t4_no_resp", resp.size(), 4);
        pop_chk(4'h1);
        wait_accept();
        tick(); tick();
        chk("t4_resp", resp.size() > 4 ? resp[4] : 2'b11, 2'b10);
        pop_chk(4'h2); pop_chk(4'h3); pop_chk(4'h4); pop_chk(4'h9);
        chk("t4_empty", empty, 1'b1);

        // 5: push and pop on the same edge
        do_reset();
        send(1'b0, 4'h7, gp(4'h7));
        send(1'b1, 4'h8, gp(4'h8));
        rx_seq = 0; rx_data = 4'hC; rx_par = gp(4'hC); rx_valid = 1;
        wait_accept();
        rd_en = 1;
        tick();
        rd_en = 0;
        chk("t5_dout", dout, 4'h7);
        chk("t5_dv", dout_valid, 1'b1);
        tick();
        pop_chk(4'h8);
        pop_chk(4'hC);
        chk("t5_empty", empty, 1'b1);

        // 6: reset mid-frame, then counter saturation
        do_reset();
        rx_seq = 0; rx_data = 4'h1; rx_par = gp(4'h1); rx_valid = 1;
        wait_accept();
        rst = 1;
        tick();
        rst = 0;
        repeat (4) tick();
        chk("t6_no_resp", resp.size(), 0);
        chk("t6_empty", empty, 1'b1);
        chk("t6_dout", dout, 4'h0);
        chk("t6_ack_seq", ack_seq, 1'b0);
        send(1'b0, 4'hE, gp(4'hE));
        chk("t6_seq0_ack", resp.size() > 0 ? resp[0] : 2'b11, 2'b10);
        pop_chk(4'hE);
        for (int i = 0; i < 255; i++) send(1'b1, 4'h1, ~gp(4'h1));
        chk("t6_nack_255", nack_cnt, 255);
        send(1'b1, 4'h1, ~gp(4'h1));
        chk("t6_nack_sat", nack_cnt, 255);

        // Random traffic with occasional resets, checked by the model every cycle
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rx_valid = 1'($urandom_range(0, 1));
            rx_data  = 4'($urandom);
            rx_seq   = 1'($urandom);
            rx_par   = gp(rx_data) ^ ($urandom_range(0, 4) == 0);
            rd_en    = ($urandom_range(0, 2) == 0);
            rst      = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 0; rx_valid = 0; rd_en = 0;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
